// File: rtl/sp_ram_sync.sv
// ---------------------------------------------------------------------------
// sp_ram_sync
// Parametrised synchronous single-port RAM with separate write/read data
// ports, per-byte write enables, selectable read-during-write behaviour, an
// optional output register and a one-word-per-cycle hardware clear sweep.
//
// Ports:
//   clk_i     clock, all state updates on the rising edge
//   rst_i     synchronous active-high reset, starts a clear sweep
//   clr_i     clear-sweep request, only honoured in IDLE
//   en_i      one-cycle access request
//   we_i      1 = write, 0 = read (qualified by en_i)
//   be_i      byte write enables, bit k covers data bits 8k+7..8k
//   addr_i    word address
//   wdata_i   write data
//   rdata_o   read data, holds its value while rvalid_o is low
//   rvalid_o  one-cycle pulse per response
//   busy_o    clear sweep in progress, accesses are ignored
// ---------------------------------------------------------------------------
module sp_ram_sync #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR     = 3,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [WIDTH/8-1:0] be_i,
  input  logic [ADDR-1:0]    addr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic [WIDTH-1:0]   rdata_o,
  output logic               rvalid_o,
  output logic               busy_o
);

  localparam int              NBYTES    = WIDTH / 8;
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);
  localparam logic [ADDR:0]   DEPTH_W   = (ADDR + 1)'(DEPTH);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_e;

  state_e          state_q, state_d;
  logic [ADDR-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             accept;
  logic             inRange;
  logic [WIDTH-1:0] oldWord;
  logic [WIDTH-1:0] mergedWord;
  logic             respValid;
  logic [WIDTH-1:0] respData;

  // Response pipeline: stage 1 is the array read, stage 2 the optional
  // output register. Data registers only load on a response so rdata holds.
  logic             rvalid1_q, rvalid2_q;
  logic [WIDTH-1:0] rdata1_q, rdata2_q;

  // Access decode. clr has priority over a same-cycle access, and nothing is
  // accepted while sweeping. Out-of-range words read as zero.
  always_comb begin
    accept  = (state_q == IDLE) && !clr_i && en_i;
    inRange = ({1'b0, addr_i} < DEPTH_W);
    oldWord = '0;
    if (inRange) begin
      oldWord = mem_q[addr_i];
    end
    mergedWord = oldWord;
    for (int k = 0; k < NBYTES; k++) begin
      if (be_i[k]) begin
        mergedWord[8*k +: 8] = wdata_i[8*k +: 8];
      end
    end
  end

  // Response selection: reads always respond; writes respond with the old
  // word, the merged word or not at all depending on RDW_MODE.
  always_comb begin
    respValid = 1'b0;
    respData  = oldWord;
    if (accept) begin
      if (!we_i) begin
        respValid = 1'b1;
      end else begin
        case (RDW_MODE)
          0: respValid = 1'b1;
          1: begin
            respValid = 1'b1;
            respData  = inRange ? mergedWord : '0;
          end
          default: respValid = 1'b0;
        endcase
      end
    end
  end

  // Next-state logic: sweep one word per cycle, leave CLEAR once the last
  // word has been written. clr is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + ADDR'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // State register. Holding rst keeps the counter pinned at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage array, deliberately not reset: the sweep clears it word by word.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (accept && we_i && inRange) begin
        mem_q[addr_i] <= mergedWord;
      end
    end
  end

  // Response pipeline keeps running during CLEAR so accesses accepted before
  // a clr still complete; reset flushes everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid1_q <= 1'b0;
      rdata1_q  <= '0;
      rvalid2_q <= 1'b0;
      rdata2_q  <= '0;
    end else begin
      rvalid1_q <= respValid;
      if (respValid) begin
        rdata1_q <= respData;
      end
      rvalid2_q <= rvalid1_q;
      if (rvalid1_q) begin
        rdata2_q <= rdata1_q;
      end
    end
  end

  assign rdata_o  = (OUT_REG != 0) ? rdata2_q : rdata1_q;
  assign rvalid_o = (OUT_REG != 0) ? rvalid2_q : rvalid1_q;
  assign busy_o   = (state_q == CLEAR);

endmodule

// File: tb/tb_sp_ram_sync.sv
// ---------------------------------------------------------------------------
// tb_sp_ram_sync
// Directed testbench for sp_ram_sync. Four instances share one stimulus bus:
//   A: DEPTH 8, read-first,   no output register
//   B: DEPTH 8, write-first,  output register
//   C: DEPTH 8, no-change,    no output register
//   D: DEPTH 6, write-first,  no output register (out-of-range cases)
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, half a cycle after the rising edge that produced them.
// ---------------------------------------------------------------------------
module tb_sp_ram_sync;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        en;
  logic        we;
  logic [1:0]  be;
  logic [2:0]  addr;
  logic [15:0] wdata;

  logic [15:0] rdataA, rdataB, rdataC, rdataD;
  logic        rvalidA, rvalidB, rvalidC, rvalidD;
  logic        busyA, busyB, busyC, busyD;

  int checks;
  int errors;

  logic [15:0] zeroFull  [8];
  logic [15:0] zeroSmall [8];
  logic [15:0] seqFull   [8];
  logic [15:0] seqSmall  [8];

  sp_ram_sync #(.WIDTH(16), .DEPTH(8), .ADDR(3), .RDW_MODE(0), .OUT_REG(0)) dutA (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdataA), .rvalid_o(rvalidA), .busy_o(busyA)
  );

  sp_ram_sync #(.WIDTH(16), .DEPTH(8), .ADDR(3), .RDW_MODE(1), .OUT_REG(1)) dutB (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdataB), .rvalid_o(rvalidB), .busy_o(busyB)
  );

  sp_ram_sync #(.WIDTH(16), .DEPTH(8), .ADDR(3), .RDW_MODE(2), .OUT_REG(0)) dutC (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdataC), .rvalid_o(rvalidC), .busy_o(busyC)
  );

  sp_ram_sync #(.WIDTH(16), .DEPTH(6), .ADDR(3), .RDW_MODE(1), .OUT_REG(0)) dutD (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdataD), .rvalid_o(rvalidD), .busy_o(busyD)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle worth of access inputs (clr is driven separately).
  task automatic applyStimulus(input logic enV, input logic weV, input logic [1:0] beV,
                               input logic [2:0] addrV, input logic [15:0] wdataV);
    en    = enV;
    we    = weV;
    be    = beV;
    addr  = addrV;
    wdata = wdataV;
  endtask

  // Reads addresses 0..7 back to back and checks every response in order,
  // then checks that no extra pulse follows.
  task automatic streamCheck(input string tag, input logic [15:0] expFull [8],
                             input logic [15:0] expSmall [8]);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) applyStimulus(1'b1, 1'b0, 2'b00, 3'(i), 16'h0000);
      else       applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000);
      @(negedge clk);
      if (i < 8) begin
        checkOutput($sformatf("%s A valid[%0d]", tag, i), 32'(rvalidA), 32'd1);
        checkOutput($sformatf("%s A data[%0d]", tag, i), 32'(rdataA), 32'(expFull[i]));
        checkOutput($sformatf("%s C data[%0d]", tag, i), 32'(rdataC), 32'(expFull[i]));
        checkOutput($sformatf("%s D valid[%0d]", tag, i), 32'(rvalidD), 32'd1);
        checkOutput($sformatf("%s D data[%0d]", tag, i), 32'(rdataD), 32'(expSmall[i]));
      end
      if (i > 0) begin
        checkOutput($sformatf("%s B valid[%0d]", tag, i - 1), 32'(rvalidB), 32'd1);
        checkOutput($sformatf("%s B data[%0d]", tag, i - 1), 32'(rdataB), 32'(expFull[i - 1]));
      end
    end
    @(negedge clk);
    checkOutput({tag, " no extra pulse"}, 32'({rvalidA, rvalidB, rvalidC, rvalidD}), 32'd0);
  endtask

  // Counts busy cycles from the current falling edge; optionally pokes
  // writes and clr while every instance is busy to show they are ignored.
  task automatic measureSweep(input string tag, input bit poke);
    int cntA = 0;
    int cntB = 0;
    int cntD = 0;
    logic anyValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cntA += int'(busyA);
      cntB += int'(busyB);
      cntD += int'(busyD);
      if (poke && busyD && busyA) begin
        applyStimulus(1'b1, 1'b1, 2'b11, 3'd2, 16'hFFFF);
        clr = 1'b1;
      end else begin
        applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000);
        clr = 1'b0;
      end
      @(negedge clk);
      anyValid |= rvalidA | rvalidB | rvalidC | rvalidD;
    end
    clr = 1'b0;
    checkOutput({tag, " busy cycles A"}, 32'(cntA), 32'd8);
    checkOutput({tag, " busy cycles B"}, 32'(cntB), 32'd8);
    checkOutput({tag, " busy cycles D"}, 32'(cntD), 32'd6);
    checkOutput({tag, " rvalid during sweep"}, 32'(anyValid), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) begin
      zeroFull[i]  = 16'h0000;
      zeroSmall[i] = 16'h0000;
      seqFull[i]   = 16'hC000 | 16'(i);
      seqSmall[i]  = (i < 6) ? (16'hC000 | 16'(i)) : 16'h0000;
    end

    // Reset state
    rst = 1'b1;
    clr = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset busy A", 32'(busyA), 32'd1);
    checkOutput("reset rvalid A", 32'(rvalidA), 32'd0);
    checkOutput("reset rdata A", 32'(rdataA), 32'd0);
    checkOutput("reset rdata B", 32'(rdataB), 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("initial sweep done A", 32'(busyA), 32'd0);

    // Fill every word with FFFF, then pulse reset and re-sweep
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b11, 3'(i), 16'hFFFF);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000);
    repeat (3) @(negedge clk);
    checkOutput("fill rdata B before reset", 32'(rdataB), 32'hFFFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst clears rdata B", 32'(rdataB), 32'd0);
    checkOutput("rst rvalid B", 32'(rvalidB), 32'd0);
    measureSweep("rstSweep", 1'b0);
    streamCheck("zeroAfterRst", zeroFull, zeroSmall);

    // Byte enables: A5A5 then 1234 on the low byte only -> A534
    applyStimulus(1'b1, 1'b1, 2'b11, 3'd3, 16'hA5A5);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 2'b01, 3'd3, 16'h1234);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 2'b00, 3'd3, 16'h0000);
    @(negedge clk);
    checkOutput("be read A valid", 32'(rvalidA), 32'd1);
    checkOutput("be read A data", 32'(rdataA), 32'hA534);
    checkOutput("be read C data", 32'(rdataC), 32'hA534);
    checkOutput("be read D data", 32'(rdataD), 32'hA534);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000);
    @(negedge clk);
    checkOutput("be read B valid", 32'(rvalidB), 32'd1);
    checkOutput("be read B data", 32'(rdataB), 32'hA534);
    checkOutput("be A no pulse", 32'(rvalidA), 32'd0);
    checkOutput("be A data held", 32'(rdataA), 32'hA534);

    // Read-during-write on word 5: 0001 then 00F0
    applyStimulus(1'b1, 1'b1, 2'b11, 3'd5, 16'h0001);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 2'b11, 3'd5, 16'h00F0);
    @(negedge clk);
    checkOutput("rdw read-first valid", 32'(rvalidA), 32'd1);
    checkOutput("rdw read-first data", 32'(rdataA), 32'h0001);
    checkOutput("rdw no-change valid", 32'(rvalidC), 32'd0);
    checkOutput("rdw no-change data held", 32'(rdataC), 32'hA534);
    checkOutput("rdw write-first D valid", 32'(rvalidD), 32'd1);
    checkOutput("rdw write-first D data", 32'(rdataD), 32'h00F0);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000);
    @(negedge clk);
    checkOutput("rdw write-first B valid", 32'(rvalidB), 32'd1);
    checkOutput("rdw write-first B data", 32'(rdataB), 32'h00F0);

    // Streaming reads after distinct writes
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b11, 3'(i), 16'hC000 | 16'(i));
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000);
    repeat (3) @(negedge clk);
    streamCheck("stream", seqFull, seqSmall);

    // Access accepted just before clr drains; the read sharing the clr cycle is dropped
    applyStimulus(1'b1, 1'b0, 2'b00, 3'd4, 16'h0000);
    @(negedge clk);
    checkOutput("drain A data", 32'(rdataA), 32'hC004);
    clr = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b00, 3'd1, 16'h0000);
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clr busy A", 32'(busyA), 32'd1);
    checkOutput("clr dropped read A", 32'(rvalidA), 32'd0);
    checkOutput("drain B valid in CLEAR", 32'(rvalidB), 32'd1);
    checkOutput("drain B data in CLEAR", 32'(rdataB), 32'hC004);
    measureSweep("clrSweep", 1'b1);
    streamCheck("zeroAfterClr", zeroFull, zeroSmall);

    // Reset in the middle of a sweep restarts it
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid-sweep busy A", 32'(busyA), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    measureSweep("midSweepRst", 1'b0);

    // Out of range on the 6-word instance
    applyStimulus(1'b1, 1'b1, 2'b11, 3'd5, 16'h1357);
    @(negedge clk);
    checkOutput("D in-range write data", 32'(rdataD), 32'h1357);
    applyStimulus(1'b1, 1'b1, 2'b11, 3'd7, 16'hBEEF);
    @(negedge clk);
    checkOutput("D oor write valid", 32'(rvalidD), 32'd1);
    checkOutput("D oor write data", 32'(rdataD), 32'h0000);
    checkOutput("A write 7 old data", 32'(rdataA), 32'h0000);
    applyStimulus(1'b1, 1'b0, 2'b00, 3'd7, 16'h0000);
    @(negedge clk);
    checkOutput("D oor read valid", 32'(rvalidD), 32'd1);
    checkOutput("D oor read data", 32'(rdataD), 32'h0000);
    checkOutput("A read 7 data", 32'(rdataA), 32'hBEEF);
    checkOutput("B write 7 data", 32'(rdataB), 32'hBEEF);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000);
    @(negedge clk);
    checkOutput("B read 7 valid", 32'(rvalidB), 32'd1);
    checkOutput("B read 7 data", 32'(rdataB), 32'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sp_ram_sync.md
Name: sp_ram_sync

Overview:
- Parametrised, synchronous, single-port RAM.
- Next generation of the team's small asynchronous single-port memories.
- Replaces the tri-state data bus with separate write and read data ports.
- Adds per-byte write enables, selectable read-during-write mode, an optional output register, and a hardware clear sweep (one word per cycle) in place of a combinational whole-array reset.

Parameters:
- WIDTH, 16: data word width in bits; must be a multiple of 8.
- DEPTH, 8: number of words; need not be a power of two.
- ADDR, 3: address width; must satisfy 2**ADDR >= DEPTH.
- RDW_MODE, 0: read-during-write behaviour. 0 = read-first (old data), 1 = write-first (new data), 2 = no-change.
- OUT_REG, 0: 0 = read latency 1; 1 = read latency 2 (extra output register).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous, active-high; forces the clear sweep.
- clr, input, 1: request a clear sweep; sampled only in IDLE.
- en, input, 1: access request, valid for one cycle.
- we, input, 1: write qualifier; 1 = write, 0 = read (with en).
- be, input, WIDTH/8: byte write enables; bit k covers data bits 8k+7..8k.
- addr, input, ADDR: word address.
- wdata, input, WIDTH: write data.
- rdata, output, WIDTH: read data; holds its value when rvalid is 0.
- rvalid, output, 1: rdata valid this cycle (single-cycle pulse per access).
- busy, output, 1: clear sweep in progress; accesses are ignored.

Behaviour:
- State machine states: CLEAR and IDLE.
- Reset (rst=1 at an edge):
  - state <= CLEAR, sweep counter <= 0.
  - rdata <= 0, rvalid <= 0, busy <= 1.
  - Any access in the pipeline is discarded, including the OUT_REG stage.
  - rst high over several cycles holds the counter at 0.
  - Memory contents are not guaranteed until the sweep completes.
- CLEAR:
  - Each cycle, mem[cnt] <= 0 and cnt <= cnt+1.
  - When cnt == DEPTH-1 that word is written and state <= IDLE, so busy is high for exactly DEPTH cycles after rst deasserts.
  - en, clr and be are ignored; no rvalid pulses.
- IDLE:
  - clr=1 enters CLEAR with cnt=0 at the next edge; busy rises that edge.
  - If en is also high in that cycle, the access is dropped (clr has priority).
- Write (IDLE, en=1, we=1):
  - For each k with be[k]=1, byte k of mem[addr] <= wdata byte k.
  - Bytes with be[k]=0 are unchanged; be=0 writes nothing.
- Write response by RDW_MODE:
  - 0: rvalid pulses; rdata = pre-write word.
  - 1: rvalid pulses; rdata = post-merge word.
  - 2: no rvalid; rdata holds its previous value.
- Read (IDLE, en=1, we=0): rdata = mem[addr] with rvalid=1, timed as follows.
  - OUT_REG=0: at edge N+1 after request edge N.
  - OUT_REG=1: at edge N+2.
- Throughput: back-to-back accesses allowed every cycle. Responses stay in order, one rvalid per accepted access.
- Read of an address written in the previous cycle returns the new data (no hazard).
- Out of range (addr >= DEPTH):
  - Writes are ignored.
  - Reads return 0 with rvalid=1.
  - Write-first/read-first responses return 0.
- rvalid is 0 in any cycle without a response. rdata is never driven to X after reset.
- Pipeline drain on clr: accesses accepted before clr still complete their rvalid during the first CLEAR cycle(s). Only accesses presented while busy=1, or in the clr cycle itself, are dropped.

Test Plan:
- Reset sweep: fill all 8 words with 16'hFFFF.
  - Pulse rst for 1 cycle -> busy=1 for exactly 8 cycles, rvalid=0 throughout.
  - Then reads of addr 0..7 -> rdata=16'h0000 each.
- Byte enables:
  - Write addr 3, wdata=16'hA5A5, be=2'b11; then write 16'h1234 with be=2'b01.
  - Read addr 3 -> 16'hA534 after 1 cycle (OUT_REG=0), 2 cycles (OUT_REG=1).
- Read-during-write: mem[5]=16'h0001, write 16'h00F0 with be=2'b11.
  - RDW_MODE=0 -> rdata=16'h0001, rvalid=1.
  - RDW_MODE=1 -> 16'h00F0, rvalid=1.
  - RDW_MODE=2 -> rvalid=0, rdata unchanged.
- Streaming: reads addr 0..7 on consecutive cycles after distinct writes.
  - Expect 8 consecutive rvalid pulses with matching data, in order, no gaps.
- clr with access: in IDLE assert clr and en(read) together.
  - No rvalid for that read; busy=1 for 8 cycles.
  - Accesses presented during busy are ignored (memory stays 0, no rvalid).
- Mid-sweep reset and out of range:
  - rst asserted at sweep cycle 4 -> sweep restarts, busy stays high for 8 more cycles.
  - With DEPTH=6: write to addr 7 is ignored; read addr 7 -> rdata=0, rvalid=1.
